// File: rtl/ovo_multi.sv
// ovo_multi: multi-line 8x8-font debug text overlay mixed into the core RGB stream.
// Optional feature: define OVO_MULTI_SHADOW_EN to dim unlit pixels inside the text window.
module ovo_multi #(
  parameter int NUM_LINES = 4,
  parameter int CHARS     = 32,
  parameter int CW        = 9,
  parameter int X0        = 16,
  parameter int Y0        = 16,
  parameter int SCALE     = 1
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic                           ce_pix,
  input  logic [CW-1:0]                  i_Hcount,
  input  logic [CW-1:0]                  i_Vcount,
  input  logic [3:0]                     i_r,
  input  logic [3:0]                     i_g,
  input  logic [3:0]                     i_b,
  input  logic                           ena,
  input  logic [NUM_LINES*CHARS*5-1:0]   text,
  input  logic [NUM_LINES*12-1:0]        line_col,
  output logic [3:0]                     o_r,
  output logic [3:0]                     o_g,
  output logic [3:0]                     o_b,
  output logic                           o_active
);
  localparam int SH  = (SCALE >= 4) ? 2 : ((SCALE == 2) ? 1 : 0);
  localparam int EW  = CW + 4;
  localparam int NCH = NUM_LINES * CHARS;
  localparam int CHW = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int LNW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int IXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [EW-1:0] X_LO = EW'(X0);
  localparam logic [EW-1:0] X_HI = EW'(X0 + CHARS * 8 * SCALE);
  localparam logic [EW-1:0] Y_LO = EW'(Y0);
  localparam logic [EW-1:0] Y_HI = EW'(Y0 + NUM_LINES * 8 * SCALE);

  // Glyph bitmaps, top row in the MSB byte, leftmost pixel in the MSB of each byte.
  function automatic logic [63:0] glyph(input logic [4:0] code);
    case (code)
      5'h00: glyph = 64'h3C66_6E76_6666_3C00;
      5'h01: glyph = 64'h1838_1818_1818_7E00;
      5'h02: glyph = 64'h3C66_060C_3060_7E00;
      5'h03: glyph = 64'h3C66_061C_0666_3C00;
      5'h04: glyph = 64'h0C1C_3C6C_7E0C_0C00;
      5'h05: glyph = 64'h7E60_7C06_0666_3C00;
      5'h06: glyph = 64'h3C60_7C66_6666_3C00;
      5'h07: glyph = 64'h7E06_0C18_3030_3000;
      5'h08: glyph = 64'h3C66_663C_6666_3C00;
      5'h09: glyph = 64'h3C66_663E_060C_3800;
      5'h0A: glyph = 64'h183C_6666_7E66_6600;
      5'h0B: glyph = 64'h7C66_667C_6666_7C00;
      5'h0C: glyph = 64'h3C66_6060_6066_3C00;
      5'h0D: glyph = 64'h786C_6666_666C_7800;
      5'h0E: glyph = 64'h7E60_6078_6060_7E00;
      5'h0F: glyph = 64'h7E60_6078_6060_6000;
      5'h10: glyph = 64'h3C66_606E_6666_3C00;
      5'h11: glyph = 64'h6666_667E_6666_6600;
      5'h12: glyph = 64'h3C18_1818_1818_3C00;
      5'h13: glyph = 64'h666C_7870_786C_6600;
      5'h14: glyph = 64'h6060_6060_6060_7E00;
      5'h15: glyph = 64'h6676_7E7E_6E66_6600;
      5'h16: glyph = 64'h3C66_6666_6666_3C00;
      5'h17: glyph = 64'h7C66_667C_6060_6000;
      5'h18: glyph = 64'h7C66_667C_786C_6600;
      5'h19: glyph = 64'h3C66_603C_0666_3C00;
      5'h1A: glyph = 64'h0018_1800_1818_0000;
      5'h1B: glyph = 64'h0000_007E_0000_0000;
      5'h1C: glyph = 64'h0000_7E00_7E00_0000;
      5'h1D: glyph = 64'h0000_0000_0018_1800;
      5'h1E: glyph = 64'h0000_0000_0000_00FF;
      default: glyph = 64'h0;
    endcase
  endfunction

  logic [NCH*5-1:0]        r_text_sh;
  logic [NUM_LINES*12-1:0] r_col_sh;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_text_sh <= '1;
      r_col_sh  <= '0;
    end else if (ce_pix && i_Hcount == '0 && i_Vcount == '0) begin
      r_text_sh <= text;
      r_col_sh  <= line_col;
    end
  end

  logic [4:0]  w_code [NCH];
  logic [11:0] w_lcol [NUM_LINES];
  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_code
    assign w_code[gi] = r_text_sh[(gi / CHARS) * CHARS * 5 + (CHARS - 1 - (gi % CHARS)) * 5 +: 5];
  end
  for (gi = 0; gi < NUM_LINES; gi++) begin : g_lcol
    assign w_lcol[gi] = r_col_sh[gi * 12 +: 12];
  end

  // Widened compare so a window that runs past the counter range never wraps back in.
  logic [EW-1:0]  w_h, w_v, w_dx, w_dy;
  logic           w_inside;
  logic [CHW-1:0] w_char;
  logic [LNW-1:0] w_line;
  logic [2:0]     w_col, w_row;
  assign w_h      = EW'(i_Hcount);
  assign w_v      = EW'(i_Vcount);
  assign w_dx     = w_h - X_LO;
  assign w_dy     = w_v - Y_LO;
  assign w_inside = (w_h >= X_LO) && (w_h < X_HI) && (w_v >= Y_LO) && (w_v < Y_HI);
  assign w_char   = CHW'(w_dx >> (SH + 3));
  assign w_col    = 3'(w_dx >> SH);
  assign w_line   = LNW'(w_dy >> (SH + 3));
  assign w_row    = 3'(w_dy >> SH);

  logic           r_s1_vld, r_s1_inside, r_s1_ena;
  logic [CHW-1:0] r_s1_char;
  logic [LNW-1:0] r_s1_line;
  logic [2:0]     r_s1_col, r_s1_row;
  logic [11:0]    r_s1_rgb;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_inside <= 1'b0;
      r_s1_ena    <= 1'b0;
      r_s1_char   <= '0;
      r_s1_line   <= '0;
      r_s1_col    <= '0;
      r_s1_row    <= '0;
      r_s1_rgb    <= '0;
    end else if (ce_pix) begin
      r_s1_vld    <= 1'b1;
      r_s1_inside <= w_inside;
      r_s1_ena    <= ena;
      r_s1_char   <= w_char;
      r_s1_line   <= w_line;
      r_s1_col    <= w_col;
      r_s1_row    <= w_row;
      r_s1_rgb    <= {i_r, i_g, i_b};
    end
  end

  logic [IXW-1:0] w_idx;
  logic [63:0]    w_glyph;
  logic [7:0]     w_row_bits;
  logic           w_hit;
  assign w_idx      = IXW'(int'(r_s1_line) * CHARS + int'(r_s1_char));
  assign w_glyph    = glyph(w_code[w_idx]);
  assign w_row_bits = w_glyph[{~r_s1_row, 3'b000} +: 8];
  assign w_hit      = r_s1_vld & r_s1_inside & r_s1_ena;

  logic        r_s2_lit;
  logic [11:0] r_s2_lcol, r_s2_rgb;
`ifdef OVO_MULTI_SHADOW_EN
  logic        r_s2_in;
  always_ff @(posedge clk_sys) begin
    if (reset)       r_s2_in <= 1'b0;
    else if (ce_pix) r_s2_in <= w_hit;
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s2_lit  <= 1'b0;
      r_s2_lcol <= '0;
      r_s2_rgb  <= '0;
    end else if (ce_pix) begin
      r_s2_lit  <= w_hit & w_row_bits[~r_s1_col];
      r_s2_lcol <= w_lcol[r_s1_line];
      r_s2_rgb  <= r_s1_rgb;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {o_r, o_g, o_b} <= '0;
      o_active        <= 1'b0;
    end else if (ce_pix) begin
      o_active <= r_s2_lit;
      if (r_s2_lit)
        {o_r, o_g, o_b} <= r_s2_lcol;
`ifdef OVO_MULTI_SHADOW_EN
      else if (r_s2_in)
        {o_r, o_g, o_b} <= {1'b0, r_s2_rgb[11:9], 1'b0, r_s2_rgb[7:5], 1'b0, r_s2_rgb[3:1]};
`endif
      else
        {o_r, o_g, o_b} <= r_s2_rgb;
    end
  end
endmodule

// File: tb/tb_ovo_multi.sv
// Randomized self-checking bench for ovo_multi: SCALE=1 (CW=9) and SCALE=2 (CW=10) instances
// share stimulus and are compared against a pixel-level reference model.
module tb_ovo_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, ce_pix, ena;
  logic [9:0]   hc, vc;
  logic [3:0]   ir, ig, ib;
  logic [639:0] text_bus;
  logic [47:0]  lcol_bus;
  logic [3:0]   r1, g1, b1, r2, g2, b2;
  logic         a1, a2;

  ovo_multi #(.CW(9), .SCALE(1)) u1 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .i_Hcount(hc[8:0]), .i_Vcount(vc[8:0]),
    .i_r(ir), .i_g(ig), .i_b(ib), .ena(ena), .text(text_bus), .line_col(lcol_bus),
    .o_r(r1), .o_g(g1), .o_b(b1), .o_active(a1));

  ovo_multi #(.CW(10), .SCALE(2)) u2 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .i_Hcount(hc), .i_Vcount(vc),
    .i_r(ir), .i_g(ig), .i_b(ib), .ena(ena), .text(text_bus), .line_col(lcol_bus),
    .o_r(r2), .o_g(g2), .o_b(b2), .o_active(a2));

  int n_chk = 0;
  int n_pass = 0;

  logic [4:0]  b_code [4][32];
  logic [11:0] b_col  [4];
  logic [4:0]  m_code [2][4][32];
  logic [11:0] m_col  [2][4];
  logic [12:0] q1[$], q2[$];
  logic [12:0] last1, last2;

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got act/rgb=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] font_row(input logic [4:0] code, input int row);
    logic [63:0] g;
    case (code)
      5'h00:   g = 64'h3C666E7666663C00;
      5'h01:   g = 64'h1838181818187E00;
      5'h0A:   g = 64'h183C66667E666600;
      5'h12:   g = 64'h3C18181818183C00;
      5'h1E:   g = 64'h00000000000000FF;
      default: g = 64'h0;
    endcase
    return g[63 - 8 * row -: 8];
  endfunction

  // Expected {active, rgb} for one pixel as seen by instance inst (0: SCALE 1, 1: SCALE 2).
  function automatic logic [12:0] model(input int inst, input int h, input int v,
                                        input logic en, input logic [11:0] rgb);
    int sc, hh, vv, dx, dy, ch, col, ln, row;
    logic [7:0] bits;
    sc = inst ? 2 : 1;
    hh = inst ? h : h % 512;
    vv = inst ? v : v % 512;
    if (!en || hh < 16 || hh >= 16 + 256 * sc || vv < 16 || vv >= 16 + 32 * sc)
      return {1'b0, rgb};
    dx = hh - 16; dy = vv - 16;
    ch = dx / (8 * sc); col = (dx / sc) % 8;
    ln = dy / (8 * sc); row = (dy / sc) % 8;
    bits = font_row(m_code[inst][ln][ch], row);
    if (bits[7 - col]) return {1'b1, m_col[inst][ln]};
`ifdef OVO_MULTI_SHADOW_EN
    return {1'b0, 1'b0, rgb[11:9], 1'b0, rgb[7:5], 1'b0, rgb[3:1]};
`else
    return {1'b0, rgb};
`endif
  endfunction

  task automatic drive_bus();
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 32; c++) text_bus[l * 160 + (31 - c) * 5 +: 5] = b_code[l][c];
      lcol_bus[l * 12 +: 12] = b_col[l];
    end
  endtask

  task automatic blank_models();
    for (int i = 0; i < 2; i++)
      for (int l = 0; l < 4; l++) begin
        m_col[i][l] = 12'h000;
        for (int c = 0; c < 32; c++) m_code[i][l][c] = 5'h1F;
      end
    q1 = {13'h0, 13'h0};
    q2 = {13'h0, 13'h0};
    last1 = 13'h0;
    last2 = 13'h0;
  endtask

  task automatic step(input int h, input int v, input string tag);
    hc = 10'(h); vc = 10'(v); ce_pix = 1'b1;
    drive_bus();
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && h % 512 == 0 && v % 512 == 0) || (i == 1 && h == 0 && v == 0))
        for (int l = 0; l < 4; l++) begin
          m_col[i][l] = b_col[l];
          for (int c = 0; c < 32; c++) m_code[i][l][c] = b_code[l][c];
        end
    end
    q1.push_back(model(0, h, v, ena, {ir, ig, ib}));
    q2.push_back(model(1, h, v, ena, {ir, ig, ib}));
    @(posedge clk); #1;
    last1 = q1.pop_front();
    last2 = q2.pop_front();
    check($sformatf("%s_s1 h=%0d v=%0d", tag, h, v), {a1, r1, g1, b1}, last1);
    check($sformatf("%s_s2 h=%0d v=%0d", tag, h, v), {a2, r2, g2, b2}, last2);
  endtask

  task automatic idle(input int n, input string tag);
    ce_pix = 1'b0;
    repeat (n) begin
      hc = 10'($urandom_range(0, 300)); vc = 10'($urandom_range(0, 60));
      {ir, ig, ib} = 12'($urandom);
      @(posedge clk); #1;
      check({tag, "_s1"}, {a1, r1, g1, b1}, last1);
      check({tag, "_s2"}, {a2, r2, g2, b2}, last2);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    hc = 10'd0; vc = 10'd0;
    repeat (n) begin
      ce_pix = ~ce_pix;
      {ir, ig, ib} = 12'($urandom);
      @(posedge clk); #1;
      check("reset_s1", {a1, r1, g1, b1}, 13'h0);
      check("reset_s2", {a2, r2, g2, b2}, 13'h0);
    end
    reset = 1'b0;
    ce_pix = 1'b0;
    blank_models();
  endtask

  function automatic logic [4:0] rcode();
    logic [4:0] set [6];
    set = '{5'h00, 5'h01, 5'h0A, 5'h12, 5'h1E, 5'h1F};
    return set[$urandom_range(0, 5)];
  endfunction

  task automatic clear_text();
    for (int l = 0; l < 4; l++) begin
      b_col[l] = 12'($urandom);
      for (int c = 0; c < 32; c++) b_code[l][c] = 5'h1F;
    end
  endtask

  initial begin
    reset = 1'b0; ce_pix = 1'b0; ena = 1'b1;
    hc = '0; vc = '0; ir = '0; ig = '0; ib = '0;
    clear_text();
    drive_bus();

    do_reset(6);
    for (int k = 0; k < 20; k++) begin
      {ir, ig, ib} = 12'($urandom);
      step($urandom_range(1, 300), $urandom_range(10, 60), "pre_snap");
    end

    clear_text();
    b_code[0][0] = 5'h01; b_col[0] = 12'hF00;
    {ir, ig, ib} = 12'h000;
    step(0, 0, "origin");
    for (int v = 16; v < 24; v++)
      for (int h = 15; h < 25; h++) step(h, v, "glyph1");

    b_code[0][0] = 5'h0A;
    for (int h = 16; h < 24; h++) step(h, 17, "midframe");
    step(0, 0, "origin");
    for (int v = 16; v < 24; v++)
      for (int h = 16; h < 24; h++) step(h, v, "glyphA");

    b_code[3][31] = 5'h1E; b_col[3] = 12'h0F0;
    step(0, 0, "origin");
    foreach (b_col[i]) ;
    for (int k = 0; k < 2; k++) begin
      step(271, 47, "last_px"); step(272, 47, "past_w"); step(271, 48, "past_h");
      step(527, 79, "last_px"); step(528, 79, "past_w"); step(527, 80, "past_h");
      step(520, 20, "wrap"); step(511, 64, "edge");
      if (k == 0) begin b_code[3][31] = 5'h00; step(0, 0, "origin"); end
    end
    for (int v = 64; v < 80; v += 3)
      for (int h = 512; h < 529; h += 2) step(h, v, "scale2");

    ena = 1'b0; {ir, ig, ib} = 12'h5A3;
    for (int k = 0; k < 4; k++) step(16 + k, 16, "ena0");
    idle(5, "ce_low");
    ena = 1'b1; {ir, ig, ib} = 12'hFFF;
    step(16, 16, "shadow"); step(17, 16, "shadow"); step(20, 30, "shadow"); step(21, 30, "shadow");

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        for (int l = 0; l < 4; l++) begin
          b_col[l] = 12'($urandom);
          for (int c = 0; c < 32; c++) b_code[l][c] = rcode();
        end
        step(0, 0, "origin");
      end
      ena = ($urandom_range(0, 3) != 0);
      {ir, ig, ib} = 12'($urandom);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3), "hold");
      else step($urandom_range(0, 1) ? $urandom_range(10, 280) : $urandom_range(0, 560),
                $urandom_range(0, 1) ? $urandom_range(10, 50) : $urandom_range(0, 90), "rnd");
    end

    do_reset(1);
    ena = 1'b1;
    for (int k = 0; k < 30; k++) begin
      {ir, ig, ib} = 12'($urandom);
      step($urandom_range(16, 200), $urandom_range(16, 47), "post_rst");
    end
    step(0, 0, "origin");
    for (int k = 0; k < 60; k++) begin
      {ir, ig, ib} = 12'($urandom);
      step($urandom_range(16, 200), $urandom_range(16, 47), "resnap");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
